campfire_checkpoint: RTL



---
 rtl/game_pkg.sv | 23 ++
 rtl/campfire_checkpoint_if.sv | 24 ++
 rtl/aabb_overlap.sv | 30 +++
 rtl/campfire_checkpoint.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-block definitions: packed state-word field positions,
// checkpoint FSM states and a small coordinate helper.
package game_pkg;

    localparam int X_MSB   = 31;
    localparam int X_LSB   = 22;
    localparam int Y_MSB   = 21;
    localparam int Y_LSB   = 12;
    localparam int COORD_W = 10;

    typedef enum logic [1:0] {
        UNLIT  = 2'd0,
        ARMING = 2'd1,
        LIT    = 2'd2
    } cp_state_e;

    // Screen coordinates never go negative, so subtraction clamps at zero.
    function automatic logic [COORD_W-1:0] sat_sub(input logic [COORD_W-1:0] a,
                                                   input logic [COORD_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/campfire_checkpoint_if.sv
// Bundle between the campfire/player blocks, the checkpoint and the
// respawn/renderer consumers.
interface campfire_checkpoint_if;

    logic        frame_tick;
    logic [31:0] campfireState;
    logic [31:0] playerState;
    logic [31:0] initRespawnState;
    logic        lit;
    logic        save_pulse;
    logic [31:0] respawnState;
    logic [1:0]  animFrame;

    modport master (
        output frame_tick, campfireState, playerState, initRespawnState,
        input  lit, save_pulse, respawnState, animFrame
    );

    modport slave (
        input  frame_tick, campfireState, playerState, initRespawnState,
        output lit, save_pulse, respawnState, animFrame
    );

endinterface

// File: rtl/aabb_overlap.sv
// Axis-aligned box overlap test; boxes touching on an edge do not overlap.
module aabb_overlap
    import game_pkg::*;
(
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] aw,
    input  logic [COORD_W-1:0] ah,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    input  logic [COORD_W-1:0] bw,
    input  logic [COORD_W-1:0] bh,
    output logic               overlap
);

    // One extra bit on the far edges keeps boxes near the screen edge from wrapping.
    logic [COORD_W:0] a_right;
    logic [COORD_W:0] a_bottom;
    logic [COORD_W:0] b_right;
    logic [COORD_W:0] b_bottom;

    assign a_right  = {1'b0, ax} + {1'b0, aw};
    assign a_bottom = {1'b0, ay} + {1'b0, ah};
    assign b_right  = {1'b0, bx} + {1'b0, bw};
    assign b_bottom = {1'b0, by} + {1'b0, bh};

    assign overlap = ({1'b0, ax} < b_right)  && ({1'b0, bx} < a_right) &&
                     ({1'b0, ay} < b_bottom) && ({1'b0, by} < a_bottom);

endmodule

// File: rtl/campfire_checkpoint.sv
// Lights a campfire after the player dwells in it, latches the respawn
// point and runs the flame animation once lit.
module campfire_checkpoint
    import game_pkg::*;
#(
    parameter int unsigned BOX_W        = 16,
    parameter int unsigned BOX_H        = 16,
    parameter int unsigned PLAYER_W     = 16,
    parameter int unsigned PLAYER_H     = 16,
    parameter int unsigned DWELL_FRAMES = 30,
    parameter int unsigned ANIM_DIV     = 8,
    parameter int unsigned ANIM_FRAMES  = 4
) (
    input logic                  sim_clk,
    input logic                  reset,
    campfire_checkpoint_if.slave cp
);

    localparam int                 DIV_W      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(ANIM_DIV - 1);
    localparam logic [1:0]         FRAME_LAST = 2'(ANIM_FRAMES - 1);
    localparam logic [9:0]         DWELL_C    = 10'(DWELL_FRAMES);
    localparam logic [COORD_W-1:0] BOX_W_C    = COORD_W'(BOX_W);
    localparam logic [COORD_W-1:0] BOX_H_C    = COORD_W'(BOX_H);
    localparam logic [COORD_W-1:0] PLAYER_W_C = COORD_W'(PLAYER_W);
    localparam logic [COORD_W-1:0] PLAYER_H_C = COORD_W'(PLAYER_H);

    logic [COORD_W-1:0] cx, cy, px, py;
    logic               overlap;
    logic               unused_bits;

    assign cx = cp.campfireState[X_MSB:X_LSB];
    assign cy = cp.campfireState[Y_MSB:Y_LSB];
    assign px = cp.playerState[X_MSB:X_LSB];
    assign py = cp.playerState[Y_MSB:Y_LSB];
    assign unused_bits = ^{cp.campfireState[Y_LSB-1:0], cp.playerState[Y_LSB-1:0]};

    aabb_overlap u_overlap (
        .ax      (px),
        .ay      (py),
        .aw      (PLAYER_W_C),
        .ah      (PLAYER_H_C),
        .bx      (cx),
        .by      (cy),
        .bw      (BOX_W_C),
        .bh      (BOX_H_C),
        .overlap (overlap)
    );

    cp_state_e   state_q, state_d;
    logic [9:0]  dwell_q, dwell_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]  anim_q, anim_d;
    logic        lit_q, lit_d;
    logic        save_q, save_d;
    logic [31:0] resp_q, resp_d;
    logic        enter_lit;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d   = state_q;
        dwell_d   = dwell_q;
        div_d     = div_q;
        anim_d    = anim_q;
        lit_d     = lit_q;
        save_d    = 1'b0;
        resp_d    = resp_q;
        enter_lit = 1'b0;

        if (cp.frame_tick) begin
            unique case (state_q)
                UNLIT: begin
                    if (overlap) begin
                        if (DWELL_FRAMES == 1) begin
                            enter_lit = 1'b1;
                        end else begin
                            state_d = ARMING;
                            dwell_d = 10'd1;
                        end
                    end
                end
                ARMING: begin
                    if (!overlap) begin
                        state_d = UNLIT;
                        dwell_d = '0;
                    end else if (dwell_q + 10'd1 == DWELL_C) begin
                        enter_lit = 1'b1;
                    end else begin
                        dwell_d = dwell_q + 10'd1;
                    end
                end
                LIT: begin
                    if (div_q == DIV_LAST) begin
                        div_d  = '0;
                        anim_d = (anim_q == FRAME_LAST) ? 2'd0 : anim_q + 2'd1;
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                default: state_d = UNLIT;
            endcase
        end

        // Respawn sits one player height above the campfire so the player lands on it.
        if (enter_lit) begin
            state_d = LIT;
            lit_d   = 1'b1;
            save_d  = 1'b1;
            div_d   = '0;
            anim_d  = 2'd0;
            resp_d  = {cx, sat_sub(cy, PLAYER_H_C), 12'b0};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge sim_clk) begin
        if (reset) begin
            state_q <= UNLIT;
            dwell_q <= '0;
            div_q   <= '0;
            anim_q  <= 2'd0;
            lit_q   <= 1'b0;
            save_q  <= 1'b0;
            resp_q  <= cp.initRespawnState;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            div_q   <= div_d;
            anim_q  <= anim_d;
            lit_q   <= lit_d;
            save_q  <= save_d;
            resp_q  <= resp_d;
        end
    end

    assign cp.lit          = lit_q;
    assign cp.save_pulse   = save_q;
    assign cp.respawnState = resp_q;
    assign cp.animFrame    = anim_q;

endmodule
